text_line_fetch8x8: RTL and testbench

Scanline fetch-and-render stage that sits directly downstream of the 8x8 text array. For each upcoming scanline it reads one row of 16-bit text cells from the array's read port, looks up the matching 8-pixel font slice in the font ROM, and stores the result in a ping-pong line buffer. It then outputs one 4-bit colour index per pixel clock to the video output stage.

---
 rtl/text_line_fetch8x8.sv | 150 +++++++++++++++
 tb/tb_text_line_fetch8x8.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/text_line_fetch8x8.sv
// Prefetches one text row per scanline into a ping-pong line buffer; fetch issues one cell per cycle
// and lands in the fill buffer 3 cycles later. The display path is 2 cycles and has no backpressure.
module text_line_fetch8x8 #(
  parameter int COLS       = 80,
  parameter int ROWS       = 60,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  line_start,
  input  logic [8:0]            line_y,
  input  logic [9:0]            pixel_x,
  input  logic                  de,
  output logic [ADDR_WIDTH-1:0] ta_addr,
  output logic                  ta_rd,
  input  logic [DATA_WIDTH-1:0] ta_data,
  output logic [10:0]           font_addr,
  input  logic [7:0]            font_data,
  output logic [3:0]            pixel_color,
  output logic                  pixel_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int CW = $clog2(COLS);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         col_q;
  logic                  drain_q;
  logic [ADDR_WIDTH-1:0] base_q, base_n;
  logic [2:0]            ly_q;
  logic                  sel_q;
  logic                  in_range;

  assign in_range = 32'(line_y) < ROWS * 8;
  assign base_n   = ADDR_WIDTH'(line_y[8:3]) * ADDR_WIDTH'(COLS);

  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    ta_rd   = (state_q == FETCH);
    ta_addr = '0;
    if (ta_rd) ta_addr = base_q + ADDR_WIDTH'(col_q);
    if (line_start) begin
      state_d = in_range ? FETCH : IDLE;
    end else begin
      case (state_q)
        FETCH:   if (col_q == CW'(COLS - 1)) state_d = DRAIN;
        DRAIN:   if (drain_q) state_d = IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      drain_q <= 1'b0;
      base_q  <= '0;
      ly_q    <= '0;
      sel_q   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      if (line_start) begin
        sel_q   <= ~sel_q;
        col_q   <= '0;
        drain_q <= 1'b0;
        if (busy) overrun <= 1'b1;
        if (in_range) begin
          base_q <= base_n;
          ly_q   <= line_y[2:0];
        end
      end else if (state_q == FETCH) begin
        col_q <= col_q + 1'b1;
      end else if (state_q == DRAIN) begin
        drain_q <= 1'b1;
      end
    end
  end

  // Fetch pipeline; a line_start kills every in-flight cell of the old row.
  logic          s1_vld, s2_vld;
  logic [CW-1:0] s1_col, s2_col;
  logic [3:0]    s2_fg, s2_bg;
  logic          wr_en;

  assign font_addr = s1_vld ? {ta_data[7:0], ly_q} : 11'd0;
  assign wr_en     = s2_vld & ~line_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s1_col <= '0;
      s2_col <= '0;
      s2_fg  <= '0;
      s2_bg  <= '0;
    end else begin
      s1_vld <= ta_rd & ~line_start;
      s1_col <= col_q;
      s2_vld <= s1_vld & ~line_start;
      s2_col <= s1_col;
      s2_fg  <= ta_data[11:8];
      s2_bg  <= ta_data[15:12];
    end
  end

  // Entry layout {fg, bg, bits}; sel_q picks the display buffer, the other one fills.
  logic [15:0]   buf0 [COLS];
  logic [15:0]   buf1 [COLS];
  logic [15:0]   rd_dat;
  logic [CW-1:0] rd_idx;
  logic          col_ok;

  assign col_ok = 32'(pixel_x[9:3]) < COLS;
  assign rd_idx = col_ok ? CW'(pixel_x[9:3]) : '0;

  always_ff @(posedge clk) begin
    if (wr_en && sel_q)  buf0[s2_col] <= {s2_fg, s2_bg, font_data};
    if (wr_en && !sel_q) buf1[s2_col] <= {s2_fg, s2_bg, font_data};
    rd_dat <= sel_q ? buf1[rd_idx] : buf0[rd_idx];
  end

  logic       de_q, ok_q;
  logic [2:0] px_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q        <= 1'b0;
      ok_q        <= 1'b0;
      px_q        <= '0;
      pixel_valid <= 1'b0;
      pixel_color <= '0;
    end else begin
      de_q        <= de;
      ok_q        <= col_ok;
      px_q        <= pixel_x[2:0];
      pixel_valid <= de_q;
      // ~px_q == 7 - px_q: bit 7 is the leftmost pixel.
      if (de_q && ok_q) pixel_color <= rd_dat[~px_q] ? rd_dat[15:12] : rd_dat[11:8];
      else              pixel_color <= 4'h0;
    end
  end

endmodule

// File: tb/tb_text_line_fetch8x8.sv
// Directed bench for text_line_fetch8x8 with behavioural text array and font ROM.
module tb_text_line_fetch8x8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_start = 1'b0;
  logic [8:0]  line_y = '0;
  logic [9:0]  pixel_x = '0;
  logic        de = 1'b0;
  logic [12:0] ta_addr;
  logic        ta_rd;
  logic [15:0] ta_data;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [3:0]  pixel_color;
  logic        pixel_valid;
  logic        busy;
  logic        overrun;

  always #5 clk = ~clk;

  text_line_fetch8x8 #(.COLS(80), .ROWS(60), .ADDR_WIDTH(13), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .line_y(line_y),
    .pixel_x(pixel_x), .de(de), .ta_addr(ta_addr), .ta_rd(ta_rd), .ta_data(ta_data),
    .font_addr(font_addr), .font_data(font_data), .pixel_color(pixel_color),
    .pixel_valid(pixel_valid), .busy(busy), .overrun(overrun)
  );

  logic [15:0] tmem [4800];

  function automatic logic [7:0] font_rom(input logic [10:0] a);
    case (a)
      11'h20B: return 8'h81;
      11'h213: return 8'hF0;
      11'h21B: return 8'h3C;
      11'h283: return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    ta_data   <= (ta_addr < 13'd4800) ? tmem[ta_addr] : 16'h0000;
    font_data <= font_rom(font_addr);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [9:0] px;
    logic       de;
    logic [3:0] color;
    logic       vld;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [9:0] px, input logic d, input logic [3:0] c, input logic v);
    vec_t e;
    e.px = px; e.de = d; e.color = c; e.vld = v;
    vq.push_back(e);
  endtask

  task automatic add8(input logic [9:0] px0, input logic [31:0] colors);
    for (int j = 0; j < 8; j++) add(px0 + 10'(j), 1'b1, colors[31-4*j -: 4], 1'b1);
  endtask

  // Continuous one-pixel-per-cycle stream; each result is checked two cycles after it was driven.
  task automatic run_seg(input int lo, input int hi);
    for (int i = lo; i <= hi + 2; i++) begin
      if (i - 2 >= lo) begin
        check($sformatf("pix_color[%0d]", i - 2), pixel_color, vq[i-2].color);
        check($sformatf("pix_valid[%0d]", i - 2), pixel_valid, vq[i-2].vld);
      end
      if (i <= hi) begin
        pixel_x = vq[i].px;
        de      = vq[i].de;
      end else begin
        pixel_x = '0;
        de      = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_line(input logic [8:0] y);
    line_y     = y;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 0);
  endtask

  initial begin
    logic act;
    int   c1;

    for (int i = 0; i < 4800; i++) tmem[i] = 16'h9600;
    tmem[160] = 16'h5C42;
    tmem[165] = 16'h1A41;
    tmem[239] = 16'h3E43;
    for (int i = 240; i < 320; i++) tmem[i] = 16'h2750;

    // Buffer filled from row 2, glyph line 3
    add8(10'd40,  32'hA111_111A);
    add8(10'd0,   32'hCCCC_5555);
    add8(10'd632, 32'h33EE_EE33);
    add(10'd640,  1'b1, 4'h0, 1'b1);
    add(10'd700,  1'b1, 4'h0, 1'b1);
    add(10'd41,   1'b0, 4'h0, 1'b0);
    add(10'd1023, 1'b1, 4'h0, 1'b1);
    add(10'd40,   1'b1, 4'hA, 1'b1);
    // Buffer filled from row 2, glyph line 0 (all font slices blank)
    add(10'd40,  1'b1, 4'h1, 1'b1);
    add(10'd47,  1'b1, 4'h1, 1'b1);
    add(10'd0,   1'b1, 4'h5, 1'b1);
    add(10'd7,   1'b1, 4'h5, 1'b1);
    add(10'd639, 1'b1, 4'h3, 1'b1);
    add(10'd300, 1'b1, 4'h9, 1'b1);
    add(10'd300, 1'b0, 4'h0, 1'b0);
    // First buffer again, after an out-of-range line swapped back
    add8(10'd40, 32'hA111_111A);
    add(10'd3,   1'b1, 4'hC, 1'b1);
    // Aborted row-3 fill: columns 0..36 new, 37 onward untouched
    add(10'd280, 1'b1, 4'h7, 1'b1);
    add(10'd288, 1'b1, 4'h7, 1'b1);
    add(10'd291, 1'b1, 4'h7, 1'b1);
    add(10'd296, 1'b1, 4'h9, 1'b1);
    add(10'd304, 1'b1, 4'h9, 1'b1);
    add(10'd40,  1'b1, 4'h7, 1'b1);

    repeat (3) @(negedge clk);
    check("rst_pixel_color", pixel_color, 0);
    check("rst_pixel_valid", pixel_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_ta_addr", ta_addr, 0);
    check("rst_ta_rd", ta_rd, 0);
    check("rst_font_addr", font_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full fetch of line 19
    pulse_line(9'd19);
    for (int k = 1; k <= 90; k++) begin
      if (k == 1) begin
        check("f1_ta_addr_col0", ta_addr, 160);
        check("f1_busy_start", busy, 1);
      end
      if (k == 6) begin
        check("f1_ta_addr_col5", ta_addr, 165);
        check("f1_ta_rd_col5", ta_rd, 1);
      end
      if (k == 7)  check("f1_font_addr_col5", font_addr, 11'h20B);
      if (k == 82) check("f1_busy_last", busy, 1);
      if (k == 83) begin
        check("f1_busy_fall", busy, 0);
        check("f1_ta_rd_idle", ta_rd, 0);
      end
      @(negedge clk);
    end
    check("f1_no_overrun", overrun, 0);

    // Second fetch swaps in the first buffer
    pulse_line(9'd16);
    run_seg(0, 28);
    wait_idle("f2_idle");
    check("f2_no_overrun", overrun, 0);

    // Out-of-range line: swap only
    pulse_line(9'd480);
    act = 1'b0;
    repeat (6) begin
      act = act | busy | ta_rd;
      @(negedge clk);
    end
    check("oor480_no_fetch", act, 0);
    run_seg(29, 35);

    pulse_line(9'd500);
    act = 1'b0;
    repeat (3) begin
      act = act | busy | ta_rd;
      @(negedge clk);
    end
    check("oor500_no_fetch", act, 0);
    run_seg(36, 44);

    // Overrun: restart at t+40
    pulse_line(9'd27);
    repeat (39) @(negedge clk);
    check("ovr_pre_flag", overrun, 0);
    check("ovr_pre_font_addr", font_addr, 11'h283);
    pulse_line(9'd19);
    c1 = cyc;
    check("ovr_flag", overrun, 1);
    check("ovr_restart_addr", ta_addr, 160);
    check("ovr_flushed_font_addr", font_addr, 0);
    @(negedge clk);
    check("ovr_new_font_addr", font_addr, 11'h213);
    run_seg(45, 50);
    while (busy && (cyc - c1) < 300) @(negedge clk);
    check("ovr_busy_fall_cycle", 32'(cyc - c1), 82);
    check("ovr_flag_sticky", overrun, 1);

    // Asynchronous reset mid-fetch
    pixel_x = 10'd40;
    de      = 1'b1;
    pulse_line(9'd19);
    repeat (19) @(negedge clk);
    check("rstf_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstf_busy", busy, 0);
    check("rstf_ta_rd", ta_rd, 0);
    check("rstf_pixel_color", pixel_color, 0);
    check("rstf_pixel_valid", pixel_valid, 0);
    check("rstf_overrun", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    act = 1'b0;
    repeat (60) begin
      act = act | busy | ta_rd | (font_addr != 11'd0);
      @(negedge clk);
    end
    check("rstf_no_activity", act, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
